// File: rtl/jtopl_mmr_q_pkg.sv
// Shared definitions for the queued OPL register front-end: update-strobe bit
// positions, global register addresses, the queue entry layout and the
// operator/channel address decoder.
package jtopl_mmr_q_pkg;

    // Bit positions inside the up[] strobe vector
    localparam int UP_MULT   = 0;
    localparam int UP_KSL_TL = 1;
    localparam int UP_AR_DR  = 2;
    localparam int UP_SL_RR  = 3;
    localparam int UP_WAV    = 4;
    localparam int UP_FNUMLO = 5;
    localparam int UP_FNUMHI = 6;
    localparam int UP_FBCON  = 7;

    // Global registers in bank 0
    localparam logic [7:0] REG_TEST  = 8'h01;
    localparam logic [7:0] REG_CLKA  = 8'h02;
    localparam logic [7:0] REG_CLKB  = 8'h03;
    localparam logic [7:0] REG_TIMER = 8'h04;
    localparam logic [7:0] REG_CSM   = 8'h08;
    // Rhythm register, honoured in both banks
    localparam logic [7:0] REG_RHY   = 8'hBD;
    // OPL3 registers, low byte of the bank-1 addresses 0x104/0x105
    localparam logic [7:0] REG_4OP   = 8'h04;
    localparam logic [7:0] REG_NEW   = 8'h05;

    // One queued data write
    typedef struct packed {
        logic       bank;
        logic [7:0] regaddr;
        logic [7:0] data;
    } wr_entry_t;

    // Result of decoding a register address into a slot/channel update
    typedef struct packed {
        logic [7:0] up;
        logic [1:0] group;
        logic [2:0] sub;
    } slot_dec_t;

    // Maps a register address to its operator or channel strobe; globals and
    // invalid slot/channel numbers give up == 0.
    function automatic slot_dec_t slot_decode(input logic [7:0] ra, input logic has_wav);
        slot_dec_t  res;
        logic [3:0] lo;
        logic       op_range;
        res.up    = 8'h00;
        res.group = 2'd0;
        res.sub   = 3'd0;
        lo        = ra[3:0];
        op_range  = ((ra >= 8'h20) && (ra <= 8'h9F)) || (ra >= 8'hE0);
        if (op_range && (ra[2:0] <= 3'd5) && (ra[4:3] != 2'd3)) begin
            res.group = ra[4:3];
            res.sub   = ra[2:0];
            case (ra[7:5])
                3'd1:    res.up[UP_MULT]   = 1'b1;
                3'd2:    res.up[UP_KSL_TL] = 1'b1;
                3'd3:    res.up[UP_AR_DR]  = 1'b1;
                3'd4:    res.up[UP_SL_RR]  = 1'b1;
                3'd7:    res.up[UP_WAV]    = has_wav;
                default: res.up            = 8'h00;
            endcase
        end else if ((lo <= 4'd8) && ((ra[7:4] == 4'hA) || (ra[7:4] == 4'hB) || (ra[7:4] == 4'hC))) begin
            res.group = (lo < 4'd3) ? 2'd0 : ((lo < 4'd6) ? 2'd1 : 2'd2);
            res.sub   = (lo < 4'd6) ? lo[2:0] : {1'b0, ~&lo[2:1], lo[0]};
            case (ra[7:4])
                4'hA:    res.up[UP_FNUMLO] = 1'b1;
                4'hB:    res.up[UP_FNUMHI] = 1'b1;
                4'hC:    res.up[UP_FBCON]  = 1'b1;
                default: res.up            = 8'h00;
            endcase
        end else begin
            res.up = 8'h00;
        end
        return res;
    endfunction

endpackage

// File: rtl/jtopl_wrq.sv
// Synchronous write queue. A push into a full queue is taken when a pop happens
// in the same cycle; otherwise it is ignored and the caller flags the loss.
module jtopl_wrq #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (count_r == {(AW+1){1'b0}});
    assign full  = (count_r == FULL_CNT);
    assign dout  = mem_r[rd_ptr_r];

    // Qualify requests against the current fill level
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy guards reads
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/jtopl_mmr_q.sv
// Queued, bank-aware register front-end for OPL/OPL2/OPL3 cores. CPU data
// writes are queued at clk rate and one is decoded per cenop into slot/channel
// update strobes or global control registers.
module jtopl_mmr_q
    import jtopl_mmr_q_pkg::*;
#(
    parameter int OPL_TYPE = 1,
    parameter int QDEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic [7:0] din,
    input  logic [1:0] addr,
    input  logic       write,
    output logic       busy,
    output logic       ovf,
    output logic [7:0] up,
    output logic [7:0] up_din,
    output logic       sel_bank,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic [7:0] value_A,
    output logic [7:0] value_B,
    output logic       start_A,
    output logic       start_B,
    output logic       flagen_A,
    output logic       flagen_B,
    output logic       clr_flags,
    output logic       wave_mode,
    output logic       csm_en,
    output logic       note_sel,
    output logic       am_dep,
    output logic       vib_dep,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic [5:0] conn4op,
    output logic       opl3_new
);

    localparam logic IS_OPL3 = (OPL_TYPE == 3);
    localparam logic HAS_WAV = (OPL_TYPE != 1);

    logic [7:0]                 selreg_r [2];
    logic                       wr_bank_s;
    logic                       addr_wr_s;
    logic                       data_wr_s;
    logic                       q_pop_s;
    logic                       q_empty_s;
    logic                       q_full_s;
    wr_entry_t                  q_din_s;
    logic [$bits(wr_entry_t)-1:0] q_dout_s;
    wr_entry_t                  head_s;
    slot_dec_t                  dec_s;
    logic                       has_strobe_s;

    jtopl_wrq #(
        .WIDTH ($bits(wr_entry_t)),
        .DEPTH (QDEPTH)
    ) u_wrq (
        .clk   (clk),
        .rst   (rst),
        .push  (data_wr_s),
        .pop   (q_pop_s),
        .din   (q_din_s),
        .dout  (q_dout_s),
        .empty (q_empty_s),
        .full  (q_full_s)
    );

    assign busy = ~q_empty_s;

    // Classify the CPU access and decode the queue head
    always_comb begin
        wr_bank_s    = IS_OPL3 ? addr[1] : 1'b0;
        addr_wr_s    = write & ~addr[0];
        data_wr_s    = write & addr[0];
        q_pop_s      = cenop & ~q_empty_s;
        q_din_s      = '{bank: wr_bank_s, regaddr: selreg_r[wr_bank_s], data: din};
        head_s       = wr_entry_t'(q_dout_s);
        dec_s        = slot_decode(head_s.regaddr, HAS_WAV);
        has_strobe_s = q_pop_s & (|dec_s.up);
    end

    // Per-bank address latch, updated immediately and never queued
    always_ff @(posedge clk) begin
        if (rst) begin
            selreg_r[0] <= 8'h00;
            selreg_r[1] <= 8'h00;
        end else if (addr_wr_s) begin
            selreg_r[wr_bank_s] <= din;
        end
    end

    // Sticky overflow: a data write lost because the queue stayed full
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (data_wr_s && q_full_s && !q_pop_s) begin
            ovf <= 1'b1;
        end
    end

    // Update strobes live for one cenop period, then clear or get replaced
    always_ff @(posedge clk) begin
        if (rst) begin
            up        <= 8'h00;
            up_din    <= 8'h00;
            sel_bank  <= 1'b0;
            sel_group <= 2'd0;
            sel_sub   <= 3'd0;
        end else if (cenop) begin
            if (has_strobe_s) begin
                up        <= dec_s.up;
                up_din    <= head_s.data;
                sel_bank  <= head_s.bank;
                sel_group <= dec_s.group;
                sel_sub   <= dec_s.sub;
            end else begin
                up        <= 8'h00;
                up_din    <= 8'h00;
                sel_bank  <= 1'b0;
                sel_group <= 2'd0;
                sel_sub   <= 3'd0;
            end
        end
    end

    // Global control registers, written when their entry is popped
    always_ff @(posedge clk) begin
        if (rst) begin
            value_A   <= 8'h00;
            value_B   <= 8'h00;
            start_A   <= 1'b0;
            start_B   <= 1'b0;
            flagen_A  <= 1'b1;
            flagen_B  <= 1'b1;
            clr_flags <= 1'b0;
            wave_mode <= 1'b0;
            csm_en    <= 1'b0;
            note_sel  <= 1'b0;
            am_dep    <= 1'b0;
            vib_dep   <= 1'b0;
            rhy_en    <= 1'b0;
            rhy_kon   <= 5'd0;
            conn4op   <= 6'd0;
            opl3_new  <= 1'b0;
        end else if (cenop) begin
            clr_flags <= 1'b0;
            if (q_pop_s) begin
                if (head_s.regaddr == REG_RHY) begin
                    am_dep  <= head_s.data[7];
                    vib_dep <= head_s.data[6];
                    rhy_en  <= head_s.data[5];
                    rhy_kon <= head_s.data[4:0];
                end else if (!head_s.bank) begin
                    case (head_s.regaddr)
                        REG_TEST: wave_mode <= HAS_WAV & head_s.data[5];
                        REG_CLKA: value_A   <= head_s.data;
                        REG_CLKB: value_B   <= head_s.data;
                        REG_TIMER: begin
                            start_A   <= head_s.data[0];
                            start_B   <= head_s.data[1];
                            flagen_A  <= ~head_s.data[6];
                            flagen_B  <= ~head_s.data[5];
                            clr_flags <= head_s.data[7];
                        end
                        REG_CSM: begin
                            csm_en   <= head_s.data[7];
                            note_sel <= head_s.data[6];
                        end
                        default: clr_flags <= 1'b0;
                    endcase
                end else begin
                    case (head_s.regaddr)
                        REG_4OP: conn4op  <= IS_OPL3 ? head_s.data[5:0] : 6'd0;
                        REG_NEW: opl3_new <= IS_OPL3 & head_s.data[0];
                        default: clr_flags <= 1'b0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_jtopl_mmr_q.sv
// Bench for jtopl_mmr_q: an OPL3 instance checked every cycle against a
// queue-based reference model, with directed sequences and a decode table,
// plus an OPL instance sharing the inputs for the wave-select corner cases.
module tb_jtopl_mmr_q;

    localparam int QD = 4;

    logic       clk = 1'b0;
    logic       rst, cenop, write;
    logic [1:0] addr;
    logic [7:0] din;

    logic       busy, ovf, sel_bank, start_A, start_B, flagen_A, flagen_B, clr_flags;
    logic       wave_mode, csm_en, note_sel, am_dep, vib_dep, rhy_en, opl3_new;
    logic [7:0] up, up_din, value_A, value_B;
    logic [1:0] sel_group;
    logic [2:0] sel_sub;
    logic [4:0] rhy_kon;
    logic [5:0] conn4op;

    logic       o1_busy, o1_ovf, o1_sel_bank, o1_start_A, o1_start_B, o1_flagen_A, o1_flagen_B;
    logic       o1_clr_flags, o1_wave_mode, o1_csm_en, o1_note_sel, o1_am_dep, o1_vib_dep;
    logic       o1_rhy_en, o1_opl3_new;
    logic [7:0] o1_up, o1_up_din, o1_value_A, o1_value_B;
    logic [1:0] o1_sel_group;
    logic [2:0] o1_sel_sub;
    logic [4:0] o1_rhy_kon;
    logic [5:0] o1_conn4op;

    always #5 clk = ~clk;

    jtopl_mmr_q #(.OPL_TYPE(3), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .cenop(cenop), .din(din), .addr(addr), .write(write),
        .busy(busy), .ovf(ovf), .up(up), .up_din(up_din), .sel_bank(sel_bank),
        .sel_group(sel_group), .sel_sub(sel_sub), .value_A(value_A), .value_B(value_B),
        .start_A(start_A), .start_B(start_B), .flagen_A(flagen_A), .flagen_B(flagen_B),
        .clr_flags(clr_flags), .wave_mode(wave_mode), .csm_en(csm_en), .note_sel(note_sel),
        .am_dep(am_dep), .vib_dep(vib_dep), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
        .conn4op(conn4op), .opl3_new(opl3_new)
    );

    jtopl_mmr_q #(.OPL_TYPE(1), .QDEPTH(QD)) dut_opl1 (
        .clk(clk), .rst(rst), .cenop(cenop), .din(din), .addr(addr), .write(write),
        .busy(o1_busy), .ovf(o1_ovf), .up(o1_up), .up_din(o1_up_din), .sel_bank(o1_sel_bank),
        .sel_group(o1_sel_group), .sel_sub(o1_sel_sub), .value_A(o1_value_A), .value_B(o1_value_B),
        .start_A(o1_start_A), .start_B(o1_start_B), .flagen_A(o1_flagen_A), .flagen_B(o1_flagen_B),
        .clr_flags(o1_clr_flags), .wave_mode(o1_wave_mode), .csm_en(o1_csm_en), .note_sel(o1_note_sel),
        .am_dep(o1_am_dep), .vib_dep(o1_vib_dep), .rhy_en(o1_rhy_en), .rhy_kon(o1_rhy_kon),
        .conn4op(o1_conn4op), .opl3_new(o1_opl3_new)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // ---------------- reference model ----------------
    logic [7:0]  m_sel [2];
    logic [16:0] m_q [$];
    logic        m_ovf;
    logic [7:0]  m_up, m_din;
    logic        m_bank;
    logic [1:0]  m_grp;
    logic [2:0]  m_sub;
    logic [7:0]  m_va, m_vb;
    logic        m_sa, m_sb, m_fa, m_fb, m_clr, m_wave, m_csm, m_note, m_am, m_vib, m_rhy, m_new;
    logic [4:0]  m_kon;
    logic [5:0]  m_conn;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_sel[0] = 8'h00; m_sel[1] = 8'h00;
        m_q.delete();
        m_ovf = 1'b0; m_up = 8'h00; m_din = 8'h00; m_bank = 1'b0; m_grp = 2'd0; m_sub = 3'd0;
        m_va = 8'h00; m_vb = 8'h00; m_sa = 1'b0; m_sb = 1'b0; m_fa = 1'b1; m_fb = 1'b1;
        m_clr = 1'b0; m_wave = 1'b0; m_csm = 1'b0; m_note = 1'b0; m_am = 1'b0; m_vib = 1'b0;
        m_rhy = 1'b0; m_kon = 5'd0; m_conn = 6'd0; m_new = 1'b0;
    endtask

    // Operator/channel address rules expressed as plain arithmetic on the number
    task automatic slot_ref(input logic [7:0] r, output logic [7:0] u, output logic [1:0] g,
                            output logic [2:0] s);
        int ri, hi, lo;
        ri = int'(r); hi = ri / 16; lo = ri % 16;
        u = 8'h00; g = 2'd0; s = 3'd0;
        if (((ri >= 32 && ri < 160) || ri >= 224) && (ri % 8) <= 5 && ((ri / 8) % 4) != 3) begin
            g = 2'((ri / 8) % 4);
            s = 3'(ri % 8);
            if (hi == 2 || hi == 3)      u = 8'h01;
            else if (hi == 4 || hi == 5) u = 8'h02;
            else if (hi == 6 || hi == 7) u = 8'h04;
            else if (hi == 8 || hi == 9) u = 8'h08;
            else                         u = 8'h10;
        end else if (hi >= 10 && hi <= 12 && lo <= 8) begin
            g = 2'(lo / 3);
            s = (lo < 6) ? 3'(lo) : 3'(lo - 6);
            u = (hi == 10) ? 8'h20 : ((hi == 11) ? 8'h40 : 8'h80);
        end
    endtask

    task automatic model_cycle(input logic r, input logic c, input logic w, input logic [1:0] a,
                               input logic [7:0] d);
        logic [16:0] e;
        logic [7:0]  ra, dd, u;
        logic [1:0]  g;
        logic [2:0]  s;
        logic        bk;
        if (r) begin
            model_reset();
            return;
        end
        if (c) begin
            m_up  = 8'h00;
            m_clr = 1'b0;
            if (m_q.size() > 0) begin
                e  = m_q.pop_front();
                bk = e[16]; ra = e[15:8]; dd = e[7:0];
                slot_ref(ra, u, g, s);
                m_up = u; m_din = dd; m_bank = bk; m_grp = g; m_sub = s;
                if (ra == 8'hBD) begin
                    m_am = dd[7]; m_vib = dd[6]; m_rhy = dd[5]; m_kon = dd[4:0];
                end else if (!bk) begin
                    if (ra == 8'h01) m_wave = dd[5];
                    if (ra == 8'h02) m_va = dd;
                    if (ra == 8'h03) m_vb = dd;
                    if (ra == 8'h04) begin
                        m_sa = dd[0]; m_sb = dd[1]; m_fa = !dd[6]; m_fb = !dd[5]; m_clr = dd[7];
                    end
                    if (ra == 8'h08) begin
                        m_csm = dd[7]; m_note = dd[6];
                    end
                end else begin
                    if (ra == 8'h04) m_conn = dd[5:0];
                    if (ra == 8'h05) m_new = dd[0];
                end
            end
        end
        if (w) begin
            if (!a[0])               m_sel[a[1]] = d;
            else if (m_q.size() < QD) m_q.push_back({a[1], m_sel[a[1]], d});
            else                     m_ovf = 1'b1;
        end
    endtask

    function automatic logic [63:0] glob_dut();
        return 64'({value_A, value_B, start_A, start_B, flagen_A, flagen_B, clr_flags, wave_mode,
                    csm_en, note_sel, am_dep, vib_dep, rhy_en, rhy_kon, conn4op, opl3_new});
    endfunction

    function automatic logic [63:0] glob_model();
        return 64'({m_va, m_vb, m_sa, m_sb, m_fa, m_fb, m_clr, m_wave,
                    m_csm, m_note, m_am, m_vib, m_rhy, m_kon, m_conn, m_new});
    endfunction

    task automatic cmp_model();
        check("model_up", 64'(up), 64'(m_up));
        check("model_busy", 64'(busy), 64'(m_q.size() != 0));
        check("model_ovf", 64'(ovf), 64'(m_ovf));
        check("model_globals", glob_dut(), glob_model());
        if (m_up != 8'h00) begin
            check("model_strobe_data", 64'({up_din, sel_bank, sel_group, sel_sub}),
                  64'({m_din, m_bank, m_grp, m_sub}));
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic r, input logic c, input logic w, input logic [1:0] a,
                        input logic [7:0] d);
        rst = r; cenop = c; write = w; addr = a; din = d;
        model_cycle(r, c, w, a, d);
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    endtask

    task automatic cen();
        step(1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        step(1'b0, 1'b0, 1'b1, a, d);
    endtask

    task automatic reg_wr(input logic bank, input logic [7:0] ra, input logic [7:0] d);
        wr({bank, 1'b0}, ra);
        wr({bank, 1'b1}, d);
    endtask

    typedef struct packed {
        logic       bank;
        logic [7:0] ra;
        logic [7:0] up;
        logic [1:0] grp;
        logic [2:0] sub;
    } vec_t;

    vec_t       tbl [17];
    logic [7:0] glist [10];

    initial begin
        tbl[0]  = '{1'b0, 8'h41, 8'h02, 2'd0, 3'd1};
        tbl[1]  = '{1'b0, 8'h20, 8'h01, 2'd0, 3'd0};
        tbl[2]  = '{1'b0, 8'h35, 8'h01, 2'd2, 3'd5};
        tbl[3]  = '{1'b0, 8'h6A, 8'h04, 2'd1, 3'd2};
        tbl[4]  = '{1'b0, 8'h9D, 8'h00, 2'd0, 3'd0};
        tbl[5]  = '{1'b0, 8'h86, 8'h00, 2'd0, 3'd0};
        tbl[6]  = '{1'b0, 8'hE4, 8'h10, 2'd0, 3'd4};
        tbl[7]  = '{1'b0, 8'hF2, 8'h10, 2'd2, 3'd2};
        tbl[8]  = '{1'b0, 8'hA0, 8'h20, 2'd0, 3'd0};
        tbl[9]  = '{1'b0, 8'hB8, 8'h40, 2'd2, 3'd2};
        tbl[10] = '{1'b0, 8'hC5, 8'h80, 2'd1, 3'd5};
        tbl[11] = '{1'b0, 8'hA9, 8'h00, 2'd0, 3'd0};
        tbl[12] = '{1'b0, 8'hC3, 8'h80, 2'd1, 3'd3};
        tbl[13] = '{1'b1, 8'h20, 8'h01, 2'd0, 3'd0};
        tbl[14] = '{1'b1, 8'h8D, 8'h08, 2'd1, 3'd5};
        tbl[15] = '{1'b0, 8'hBD, 8'h00, 2'd0, 3'd0};
        tbl[16] = '{1'b0, 8'h1F, 8'h00, 2'd0, 3'd0};
        glist = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h08, 8'hBD, 8'hA8, 8'hC9, 8'hB5};

        model_reset();
        rst = 1'b1; cenop = 1'b0; write = 1'b0; addr = 2'b00; din = 8'h00;

        // Reset then idle cenops
        step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
        step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
        for (int i = 0; i < 10; i++) cen();
        check("rst_up", 64'(up), 64'(8'h00));
        check("rst_flagen", 64'({flagen_A, flagen_B}), 64'(2'b11));
        check("rst_busy", 64'(busy), 64'(1'b0));
        check("rst_ovf", 64'(ovf), 64'(1'b0));

        // Single KSL_TL write, held until the following cenop
        reg_wr(1'b0, 8'h41, 8'h3F);
        check("ksl_pending_up", 64'(up), 64'(8'h00));
        cen();
        check("ksl_up", 64'(up), 64'(8'h02));
        check("ksl_sel", 64'({sel_group, sel_sub}), 64'({2'd0, 3'd1}));
        check("ksl_din", 64'(up_din), 64'(8'h3F));
        idle(); idle();
        check("ksl_hold", 64'(up), 64'(8'h02));
        cen();
        check("ksl_clear", 64'(up), 64'(8'h00));

        // Overflow with five queued writes, then drain
        wr(2'b00, 8'hA7);
        for (int i = 0; i < 5; i++) wr(2'b01, 8'h10 + 8'(i));
        check("ovf_set", 64'(ovf), 64'(1'b1));
        check("ovf_busy", 64'(busy), 64'(1'b1));
        for (int i = 0; i < 4; i++) begin
            cen();
            check("drain_up", 64'(up), 64'(8'h20));
            check("drain_sel", 64'({sel_group, sel_sub, up_din}), 64'({2'd2, 3'd1, 8'h10 + 8'(i)}));
        end
        check("drain_busy", 64'(busy), 64'(1'b0));
        cen();
        check("drain_idle_up", 64'(up), 64'(8'h00));

        // Timer control levels and flag-clear pulse
        reg_wr(1'b0, 8'h04, 8'hE3);
        cen();
        check("tmr_start", 64'({start_A, start_B}), 64'(2'b11));
        check("tmr_flagen", 64'({flagen_A, flagen_B}), 64'(2'b00));
        check("tmr_clr", 64'(clr_flags), 64'(1'b1));
        cen();
        check("tmr_clr_once", 64'(clr_flags), 64'(1'b0));
        reg_wr(1'b0, 8'h04, 8'h00);
        cen();
        check("tmr_off", 64'({start_A, start_B, flagen_A, flagen_B, clr_flags}), 64'(5'b00110));

        // OPL3 bank 1 and OPL-only wave select
        reg_wr(1'b1, 8'h04, 8'h3F);
        cen();
        check("b1_conn4op", 64'(conn4op), 64'(6'h3F));
        check("b1_timers", 64'({start_A, start_B, flagen_A, flagen_B}), 64'(4'b0011));
        reg_wr(1'b1, 8'h20, 8'h01);
        cen();
        check("b1_mult", 64'({up, sel_bank}), 64'({8'h01, 1'b1}));
        reg_wr(1'b0, 8'hE0, 8'h55);
        cen();
        check("opl3_wav", 64'(up), 64'(8'h10));
        check("opl1_wav", 64'(o1_up), 64'(8'h00));
        reg_wr(1'b0, 8'h01, 8'h20);
        cen();
        check("opl3_wave_mode", 64'(wave_mode), 64'(1'b1));
        check("opl1_wave_mode", 64'(o1_wave_mode), 64'(1'b0));

        // Decode table
        for (int i = 0; i < 17; i++) begin
            reg_wr(tbl[i].bank, tbl[i].ra, 8'hC3 ^ 8'(i));
            cen();
            check("tbl_up", 64'({8'(i), up}), 64'({8'(i), tbl[i].up}));
            if (tbl[i].up != 8'h00) begin
                check("tbl_sel", 64'({8'(i), sel_bank, sel_group, sel_sub}),
                      64'({8'(i), tbl[i].bank, tbl[i].grp, tbl[i].sub}));
            end
            cen();
            check("tbl_clear", 64'({8'(i), up}), 64'({8'(i), 8'h00}));
        end

        // Reset while entries are still queued
        wr(2'b00, 8'hBD);
        for (int i = 0; i < 3; i++) wr(2'b01, 8'h3F);
        cen();
        check("rhy_kon_set", 64'(rhy_kon), 64'(5'h1F));
        check("rhy_queued", 64'(busy), 64'(1'b1));
        step(1'b1, 1'b0, 1'b0, 2'b00, 8'h00);
        check("midq_rst_busy", 64'(busy), 64'(1'b0));
        check("midq_rst_kon", 64'(rhy_kon), 64'(5'd0));
        check("midq_rst_out", 64'({up, ovf, flagen_A, flagen_B, conn4op}), 64'({8'h00, 1'b0, 2'b11, 6'd0}));
        cen();
        check("midq_rst_nopop", 64'(up), 64'(8'h00));

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic       rr, cc, ww;
            logic [1:0] aa;
            logic [7:0] dd;
            rr = ($urandom_range(0, 299) == 0);
            cc = ($urandom_range(0, 2) == 0);
            ww = ($urandom_range(0, 1) == 1);
            aa = 2'($urandom);
            dd = 8'($urandom);
            if (!aa[0] && $urandom_range(0, 3) == 0) dd = glist[$urandom_range(0, 9)];
            step(rr, cc, ww, aa, dd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
